// File: rtl/shift_reg_pwr_n_pkg.sv
// Shared definitions for shift_reg_pwr_n: operation-mode encodings used by RTL and bench.
package shift_reg_pwr_n_pkg;

    typedef enum logic [1:0] {
        PUSH  = 2'b00,
        CYCLE = 2'b01,
        LOAD  = 2'b10,
        HOLD  = 2'b11
    } mode_t;

endpackage

// File: rtl/toggle_acc.sv
// Counts bits that flip between the current and next register value and
// accumulates them into a saturating counter with a sticky saturation flag.
module toggle_acc #(
    parameter int N  = 4,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [N-1:0]  q_cur,
    input  logic [N-1:0]  q_next,
    output logic [CW-1:0] cnt,
    output logic          sat
);
    localparam int TW = $clog2(N + 1);

    logic [TW-1:0] toggles;
    logic [CW:0]   sum;

    always_comb begin
        toggles = '0;
        for (int i = 0; i < N; i++)
            toggles = toggles + TW'(q_cur[i] ^ q_next[i]);
    end

    // One extra bit of headroom exposes overflow; a saturated count plus any
    // nonzero toggle count overflows again, so the clamp holds by itself.
    assign sum = {1'b0, cnt} + (CW+1)'(toggles);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (sum[CW]) begin
            cnt <= '1;
            sat <= 1'b1;
        end else begin
            cnt <= sum[CW-1:0];
        end
    end

endmodule

// File: rtl/shift_reg_pwr_n.sv
// N-bit push/rotate/load shift register with an optional toggle (power) counter.
// Define PWR_CNT_EN to build the counter; otherwise PWR_CNT/PWR_SAT are tied to 0.
module shift_reg_pwr_n
    import shift_reg_pwr_n_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ENB,
    input  logic [1:0]    MODO,
    input  logic          DIR,
    input  logic [N-1:0]  D,
    input  logic          S_IN,
    input  logic          CNT_CLR,
    output logic [N-1:0]  Q,
    output logic          S_OUT,
    output logic [CW-1:0] PWR_CNT,
    output logic          PWR_SAT
);
    logic [N-1:0] q_next;
    logic         s_next;

    always_comb begin
        q_next = Q;
        s_next = S_OUT;
        if (ENB) begin
            case (mode_t'(MODO))
                PUSH: begin
                    q_next = DIR ? {S_IN, Q[N-1:1]} : {Q[N-2:0], S_IN};
                    s_next = DIR ? Q[0] : Q[N-1];
                end
                CYCLE: begin
                    q_next = DIR ? {Q[0], Q[N-1:1]} : {Q[N-2:0], Q[N-1]};
                    s_next = DIR ? Q[0] : Q[N-1];
                end
                LOAD: begin
                    q_next = D;
                    s_next = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q     <= '0;
            S_OUT <= 1'b0;
        end else begin
            Q     <= q_next;
            S_OUT <= s_next;
        end
    end

`ifdef PWR_CNT_EN
    toggle_acc #(.N(N), .CW(CW)) u_toggle_acc (
        .clk    (CLK),
        .rst    (RESET),
        .clr    (CNT_CLR),
        .q_cur  (Q),
        .q_next (q_next),
        .cnt    (PWR_CNT),
        .sat    (PWR_SAT)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = CNT_CLR;
    assign PWR_CNT = '0;
    assign PWR_SAT = 1'b0;
`endif

endmodule

// File: doc/shift_reg_pwr_n.md
SHIFT_REG_PWR_N -- requirements
Module: shift_reg_pwr_n

Interface
REQ-001 SHALL have parameter N, default 4, meaning register width in bits (N >= 2).
REQ-002 SHALL have parameter CW, default 32, meaning power-counter width (CW >= $clog2(N+1)).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ENB  input  1  shift/load enable; 0 freezes Q and S_OUT.
REQ-006 SHALL have port MODO  input  2  operation: PUSH=2'b00, CYCLE=2'b01, LOAD=2'b10, HOLD=2'b11.
REQ-007 SHALL have port DIR  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
REQ-008 SHALL have port D  input  N  parallel load data.
REQ-009 SHALL have port S_IN  input  1  serial input bit for PUSH.
REQ-010 SHALL have port CNT_CLR  input  1  synchronous clear of power counter.
REQ-011 SHALL have port Q  output  N  register contents.
REQ-012 SHALL have port S_OUT  output  1  registered bit leaving the register.
REQ-013 SHALL have port PWR_CNT  output  CW  accumulated count of Q bit toggles.
REQ-014 SHALL have port PWR_SAT  output  1  sticky flag: PWR_CNT has saturated.

Function
REQ-015 With ENB=1, LOAD SHALL set Q<=D and S_OUT<=0 on the next edge (1-cycle latency).
REQ-016 With ENB=1, PUSH DIR=0 SHALL set Q<={Q[N-2:0],S_IN}, S_OUT<=Q[N-1]; DIR=1 SHALL set Q<={S_IN,Q[N-1:1]}, S_OUT<=Q[0].
REQ-017 With ENB=1, CYCLE DIR=0 SHALL rotate left, S_OUT<=Q[N-1]; DIR=1 SHALL rotate right, S_OUT<=Q[0].
REQ-018 HOLD, or ENB=0 in any mode, SHALL keep Q and S_OUT unchanged.
REQ-019 Each edge, toggle count T = popcount(Q_next XOR Q) (0..N) SHALL be added to PWR_CNT, same edge as Q update.
REQ-020 Addition SHALL be performed at CW+1 bits; result > 2^CW-1 SHALL clamp PWR_CNT to 2^CW-1 and set PWR_SAT=1.
REQ-021 Once saturated, PWR_CNT SHALL stay at 2^CW-1 and PWR_SAT at 1 until CNT_CLR or RESET.
REQ-022 CNT_CLR=1 SHALL set PWR_CNT<=0 and PWR_SAT<=0 next edge; clear wins over a simultaneous toggle (that cycle's T discarded).
REQ-023 CNT_CLR SHALL act regardless of ENB and SHALL NOT affect Q or S_OUT.
REQ-024 ENB=0 yields T=0; counter SHALL hold.

Reset
REQ-025 RESET=1 SHALL immediately force Q=0, S_OUT=0, PWR_CNT=0, PWR_SAT=0, independent of CLK.
REQ-026 RESET asserted mid-shift SHALL abort the operation; first edge after deassertion SHALL act on current inputs from Q=0 (reset itself counts no toggles).

Configuration
REQ-027 Macro PWR_CNT_EN defined SHALL compile in the toggle counter per REQ-019..REQ-024.
REQ-028 Without PWR_CNT_EN, PWR_CNT SHALL be constant 0, PWR_SAT constant 0, CNT_CLR ignored, no counter flops; ports retained.

Structure
REQ-029 Mode encodings PUSH/CYCLE/LOAD/HOLD SHALL live in the shared definitions file, used by RTL and bench.
REQ-030 Toggle popcount and saturating accumulator SHALL be one sub-module, toggle_acc (params N, CW), instantiated only under PWR_CNT_EN.

Verification
REQ-031 N=4: RESET pulse -> Q=0000, S_OUT=0, PWR_CNT=0; then LOAD D=1101 ENB=1 -> Q=1101, PWR_CNT=3.
REQ-032 From Q=1101, PUSH DIR=0 S_IN=0 for 4 edges -> Q=1010/0100/1000/0000, S_OUT=1/1/0/1, PWR_CNT=3+3+3+2+1=12.
REQ-033 LOAD 0110 then CYCLE DIR=1 for 4 edges -> Q=0011/1001/1100/0110, S_OUT=0/1/1/0; ENB=0 next 3 edges -> Q=0110, counter unchanged.
REQ-034 CW=3: LOAD alternating 1111/0000 -> PWR_CNT=4, then 7 with PWR_SAT=1, stays 7; CNT_CLR with a toggling LOAD same edge -> PWR_CNT=0, PWR_SAT=0.
REQ-035 RESET asserted between edges during PUSH -> Q=0 immediately, no CLK edge required; PWR_CNT=0.
REQ-036 Build without PWR_CNT_EN, rerun REQ-032 -> identical Q/S_OUT sequence, PWR_CNT=0, PWR_SAT=0 throughout.
